// File: rtl/mmio_io_hub_pkg.sv
// Shared constants and helpers for the memory-mapped I/O hub.
//   - Register word offsets within the 256-byte window.
//   - bus_format (funct3) width codes.
//   - seg_decode: 4-bit value to active-low 7-segment glyph (bit 0 = segment a).
//   - Byte-lane helpers shared by the write and read paths.
package mmio_io_pkg;

  localparam logic [7:0] OFF_LED      = 8'h00;
  localparam logic [7:0] OFF_SW       = 8'h04;
  localparam logic [7:0] OFF_KEY      = 8'h08;
  localparam logic [7:0] OFF_EDGE     = 8'h0C;
  localparam logic [7:0] OFF_MASK     = 8'h10;
  localparam logic [7:0] OFF_HEXCTL   = 8'h14;
  localparam logic [7:0] OFF_HEXVAL   = 8'h18;
  localparam logic [7:0] OFF_RAW_BASE = 8'h40;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    unique case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Size code is format[1:0]; the sign bit (format[2]) only matters for loads.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mmio_io_hub_if.sv
// Core data-bus view of the I/O hub.
//   master: drives address, write_data, format, read/write strobes.
//   slave : returns registered data_fetched and hit.
interface mmio_io_hub_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  format;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] data_fetched;
  logic        hit;

  modport master (
    output address, write_data, format, read_enable, write_enable,
    input  data_fetched, hit
  );

  modport slave (
    input  address, write_data, format, read_enable, write_enable,
    output data_fetched, hit
  );
endinterface

// File: rtl/mmio_io_hub_key_debouncer.sv
// One push-button channel: 2-flop synchroniser, stability counter and debounced level.
//   clock, reset : single clock, synchronous active-low reset
//   key_n_i      : raw asynchronous active-low button
//   level_o      : debounced pressed level (1 = pressed)
//   rise_o       : high in the cycle whose edge will set level_o (press accepted)
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q, sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter holds the number of consecutive samples that disagreed with the level;
  // the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= ~key_n_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/mmio_io_hub.sv
// Register-mapped LED / switch / key / 7-segment peripheral on the core data bus.
//   clock, reset  : single clock, synchronous active-low reset
//   bus           : slave side of the data bus (address, store data, format, strobes,
//                   registered load data and hit)
//   switches      : raw switch inputs, synchronised here
//   keys_n        : raw active-low buttons, debounced per key
//   leds          : LED drive
//   hex_segments  : digit i at [7i+6:7i], active-low
//   irq           : level interrupt, |(EDGE & MASK)
module mmio_io_hub
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFF20_0000,
  parameter int unsigned NUM_LEDS        = 10,
  parameter int unsigned NUM_SWITCHES    = 8,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_HEX         = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  mmio_io_hub_if.slave            bus,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [NUM_KEYS-1:0]     keys_n,
  output logic [NUM_LEDS-1:0]     leds,
  output logic [7*NUM_HEX-1:0]    hex_segments,
  output logic                    irq
);

  localparam int unsigned HexW = 4 * NUM_HEX;

  logic                    hit, wr;
  logic [7:0]              word_off;
  logic [1:0]              lane;
  logic [3:0]              be;
  logic [31:0]             lane_mask, wdata_rep, rd_word, shifted, rd_ext;
  logic [4:0]              shamt;

  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic [NUM_KEYS-1:0]     mask_q, mask_d, edge_q, edge_d, edge_clr;
  logic                    hexctl_q, hexctl_d;
  logic [HexW-1:0]         hexval_q, hexval_d;
  logic [6:0]              raw_q [NUM_HEX];
  logic [6:0]              raw_d [NUM_HEX];
  logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;
  logic [NUM_KEYS-1:0]     key_level, key_rise;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rd_hit_q, rd_hit_d;

  assign hit      = bus.address[31:8] == BASE_ADDR[31:8];
  assign word_off = {bus.address[7:2], 2'b00};
  assign lane     = bus.address[1:0];
  assign be       = byte_enables(bus.format[1:0], lane);
  assign wr       = bus.write_enable & hit;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .key_n_i(keys_n[k]),
      .level_o(key_level[k]),
      .rise_o (key_rise[k])
    );
  end

  // Store data is replicated across lanes so each enabled lane sees its own byte.
  always_comb begin
    for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{be[b]}};
    case (bus.format[1:0])
      2'b00:   wdata_rep = {4{bus.write_data[7:0]}};
      2'b01:   wdata_rep = {2{bus.write_data[15:0]}};
      default: wdata_rep = bus.write_data;
    endcase
  end

  // Register writes
  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    hexctl_d = hexctl_q;
    hexval_d = hexval_q;
    raw_d    = raw_q;
    edge_clr = '0;
    if (wr) begin
      case (word_off)
        OFF_LED:    led_d    = NUM_LEDS'(merge_lanes(32'(led_q), wdata_rep, lane_mask));
        OFF_EDGE:   edge_clr = NUM_KEYS'(wdata_rep & lane_mask);
        OFF_MASK:   mask_d   = NUM_KEYS'(merge_lanes(32'(mask_q), wdata_rep, lane_mask));
        OFF_HEXCTL: hexctl_d = merge_lanes({31'b0, hexctl_q}, wdata_rep, lane_mask) & 32'h1;
        OFF_HEXVAL: hexval_d = HexW'(merge_lanes(32'(hexval_q), wdata_rep, lane_mask));
        default: begin
          for (int i = 0; i < NUM_HEX; i++) begin
            if (word_off == OFF_RAW_BASE + 8'(4 * i)) begin
              raw_d[i] = 7'(merge_lanes(32'(raw_q[i]), wdata_rep, lane_mask));
            end
          end
        end
      endcase
    end
    // A press accepted in the same cycle as its W1C still leaves the bit set.
    edge_d = (edge_q & ~edge_clr) | key_rise;
  end

  // Register reads, taken from current state so a same-cycle write is not visible
  always_comb begin
    rd_word = '0;
    case (word_off)
      OFF_LED:    rd_word = 32'(led_q);
      OFF_SW:     rd_word = 32'(sw_sync_q);
      OFF_KEY:    rd_word = 32'(key_level);
      OFF_EDGE:   rd_word = 32'(edge_q);
      OFF_MASK:   rd_word = 32'(mask_q);
      OFF_HEXCTL: rd_word = {31'b0, hexctl_q};
      OFF_HEXVAL: rd_word = 32'(hexval_q);
      default: begin
        for (int i = 0; i < NUM_HEX; i++) begin
          if (word_off == OFF_RAW_BASE + 8'(4 * i)) rd_word = 32'(raw_q[i]);
        end
      end
    endcase

    shamt   = (bus.format[1:0] == 2'b01) ? {lane[1], 4'b0000} : {lane, 3'b000};
    shifted = rd_word >> shamt;
    case (bus.format)
      FMT_B:   rd_ext = {{24{shifted[7]}}, shifted[7:0]};
      FMT_BU:  rd_ext = {24'b0, shifted[7:0]};
      FMT_H:   rd_ext = {{16{shifted[15]}}, shifted[15:0]};
      FMT_HU:  rd_ext = {16'b0, shifted[15:0]};
      default: rd_ext = rd_word;
    endcase

    rd_data_d = rd_data_q;
    rd_hit_d  = rd_hit_q;
    if (bus.read_enable) begin
      rd_hit_d  = hit;
      rd_data_d = hit ? rd_ext : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      led_q     <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      hexctl_q  <= 1'b1;
      hexval_q  <= '0;
      raw_q     <= '{default: 7'h7F};
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      led_q     <= led_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      hexctl_q  <= hexctl_d;
      hexval_q  <= hexval_d;
      raw_q     <= raw_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_HEX; i++) begin
      hex_segments[7*i +: 7] = hexctl_q ? raw_q[i] : seg_decode(hexval_q[4*i +: 4]);
    end
  end

  assign leds             = led_q;
  assign irq              = |(edge_q & mask_q);
  assign bus.data_fetched = rd_data_q;
  assign bus.hit          = rd_hit_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Self-checking bench for mmio_io_hub: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomised bus/key/switch traffic.
module tb_mmio_io_hub;

  localparam logic [31:0] BASE = 32'hFF20_0000;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] switches = 8'h00;
  logic [3:0] keys_n = 4'hF;
  logic [9:0] leds;
  logic [41:0] hex_segments;
  logic       irq;

  mmio_io_hub_if bus_if ();

  mmio_io_hub #(
    .BASE_ADDR      (BASE),
    .NUM_LEDS       (10),
    .NUM_SWITCHES   (8),
    .NUM_KEYS       (4),
    .NUM_HEX        (6),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if),
    .switches    (switches),
    .keys_n      (keys_n),
    .leds        (leds),
    .hex_segments(hex_segments),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  bit         m_valid = 0;
  logic [9:0] m_led;
  logic [3:0] m_mask, m_edge, m_lvl, m_k1, m_k2;
  logic       m_hexctl;
  logic [23:0] m_hexval;
  logic [6:0] m_raw [6];
  logic [7:0] m_sw1, m_sw2;
  int         m_run [4];
  logic [31:0] m_data;
  logic       m_hit;

  function automatic logic [31:0] m_reg(input logic [7:0] off);
    logic [7:0] w;
    w = {off[7:2], 2'b00};
    case (w)
      8'h00: return {22'b0, m_led};
      8'h04: return {24'b0, m_sw2};
      8'h08: return {28'b0, m_lvl};
      8'h0C: return {28'b0, m_edge};
      8'h10: return {28'b0, m_mask};
      8'h14: return {31'b0, m_hexctl};
      8'h18: return {8'b0, m_hexval};
      default: begin
        if (w >= 8'h40 && w < 8'h58) return {25'b0, m_raw[(w - 8'h40) >> 2]};
        return 32'h0;
      end
    endcase
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [2:0] f,
                                            input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = w[16*ln[1] +: 16];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] f, input logic [1:0] ln);
    logic [31:0] r;
    r = old;
    case (f[1:0])
      2'b00:   r[8*ln +: 8] = d[7:0];
      2'b01:   r[16*ln[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [41:0] m_hex();
    logic [41:0] h;
    for (int i = 0; i < 6; i++) h[7*i +: 7] = m_hexctl ? m_raw[i] : glyph[m_hexval[4*i +: 4]];
    return h;
  endfunction

  task automatic model_step();
    logic [31:0] clr, nw;
    logic [3:0]  rise, sample;
    logic [7:0]  off, w;
    logic        h;
    if (!reset) begin
      m_led = '0; m_mask = '0; m_edge = '0; m_lvl = '0; m_k1 = '0; m_k2 = '0;
      m_hexctl = 1'b1; m_hexval = '0; m_sw1 = '0; m_sw2 = '0; m_data = '0; m_hit = 1'b0;
      for (int i = 0; i < 6; i++) m_raw[i] = 7'h7F;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_valid = 1;
    end else begin
      off = bus_if.address[7:0];
      w   = {off[7:2], 2'b00};
      h   = bus_if.address[31:8] == BASE[31:8];
      if (bus_if.read_enable) begin
        m_hit  = h;
        m_data = h ? m_extract(m_reg(off), bus_if.format, off[1:0]) : 32'h0;
      end
      // A level change is accepted after D consecutive synchronised samples disagree.
      sample = m_k2;
      rise   = '0;
      for (int k = 0; k < 4; k++) begin
        if (sample[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
            rise[k]  = m_lvl[k];
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_k2 = m_k1;
      m_k1 = ~keys_n;
      clr = '0;
      if (bus_if.write_enable && h) begin
        nw = m_merge(m_reg(off), bus_if.write_data, bus_if.format, off[1:0]);
        case (w)
          8'h00: m_led = nw[9:0];
          8'h0C: clr = m_merge(32'h0, bus_if.write_data, bus_if.format, off[1:0]);
          8'h10: m_mask = nw[3:0];
          8'h14: m_hexctl = nw[0];
          8'h18: m_hexval = nw[23:0];
          default: if (w >= 8'h40 && w < 8'h58) m_raw[(w - 8'h40) >> 2] = nw[6:0];
        endcase
      end
      m_edge = (m_edge & ~clr[3:0]) | rise;
      m_sw2 = m_sw1;
      m_sw1 = switches;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("data_fetched", {32'b0, bus_if.data_fetched}, {32'b0, m_data});
      chk("bus_hit", {63'b0, bus_if.hit}, {63'b0, m_hit});
      chk("leds", {54'b0, leds}, {54'b0, m_led});
      chk("hex_segments", {22'b0, hex_segments}, {22'b0, m_hex()});
      chk("irq", {63'b0, irq}, {63'b0, |(m_edge & m_mask)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [2:0] f);
    bus_if.address = BASE + off; bus_if.write_data = d; bus_if.format = f;
    bus_if.write_enable = 1'b1; bus_if.read_enable = 1'b0;
    step();
    bus_if.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [2:0] f);
    bus_if.address = BASE + off; bus_if.format = f;
    bus_if.read_enable = 1'b1; bus_if.write_enable = 1'b0;
    step();
    bus_if.read_enable = 1'b0;
  endtask

  logic [7:0] offs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                            8'h30, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58};
  logic [2:0] fmts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    bus_if.address = '0; bus_if.write_data = '0; bus_if.format = 3'b010;
    bus_if.read_enable = 1'b0; bus_if.write_enable = 1'b0;
    idle(3);
    chk("reset_leds", {54'b0, leds}, 64'h0);
    chk("reset_hex", {22'b0, hex_segments}, {22'b0, {42{1'b1}}});
    chk("reset_irq", {63'b0, irq}, 64'h0);
    chk("reset_data", {32'b0, bus_if.data_fetched}, 64'h0);
    chk("reset_hit", {63'b0, bus_if.hit}, 64'h0);
    reset = 1'b1;
    idle(2);

    // LED word write and read back
    wr(32'h00, 32'h3FF, 3'b010);
    chk("led_write", {54'b0, leds}, 64'h3FF);
    rd(32'h00, 3'b010);
    chk("led_read", {32'b0, bus_if.data_fetched}, 64'h3FF);
    chk("led_read_hit", {63'b0, bus_if.hit}, 64'h1);
    chk("model_led_pin", {54'b0, m_led}, 64'h3FF);

    // Switches through the synchroniser, signed and unsigned byte loads
    switches = 8'hA5;
    idle(3);
    rd(32'h04, 3'b000);
    chk("sw_lb", {32'b0, bus_if.data_fetched}, 64'hFFFF_FFA5);
    rd(32'h04, 3'b100);
    chk("sw_lbu", {32'b0, bus_if.data_fetched}, 64'h0000_00A5);

    // Short glitch rejected, long press accepted
    keys_n[1] = 1'b0; idle(5); keys_n[1] = 1'b1; idle(15);
    rd(32'h08, 3'b010);
    chk("glitch_key", {32'b0, bus_if.data_fetched}, 64'h0);
    rd(32'h0C, 3'b010);
    chk("glitch_edge", {32'b0, bus_if.data_fetched}, 64'h0);
    keys_n[1] = 1'b0; idle(12);
    rd(32'h08, 3'b010);
    chk("press_key", {32'b0, bus_if.data_fetched}, 64'h2);
    rd(32'h0C, 3'b010);
    chk("press_edge", {32'b0, bus_if.data_fetched}, 64'h2);
    wr(32'h10, 32'h2, 3'b010);
    chk("press_irq", {63'b0, irq}, 64'h1);
    chk("model_edge_pin", {60'b0, m_edge}, 64'h2);

    // Release, then re-press so the new edge lands on the same edge as a W1C
    keys_n[1] = 1'b1; idle(12);
    keys_n[1] = 1'b0; idle(9);
    wr(32'h0C, 32'h2, 3'b010);
    chk("set_wins_irq", {63'b0, irq}, 64'h1);
    rd(32'h0C, 3'b010);
    chk("set_wins_edge", {32'b0, bus_if.data_fetched}, 64'h2);
    wr(32'h0C, 32'h2, 3'b010);
    chk("w1c_irq", {63'b0, irq}, 64'h0);
    rd(32'h0C, 3'b010);
    chk("w1c_edge", {32'b0, bus_if.data_fetched}, 64'h0);

    // Decode mode then back to raw
    wr(32'h14, 32'h0, 3'b010);
    wr(32'h18, 32'h00C0_FFEE, 3'b010);
    chk("hex_digit0", {57'b0, hex_segments[6:0]}, 64'h06);
    chk("hex_decode", {22'b0, hex_segments},
        {22'b0, 7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06});
    wr(32'h14, 32'h1, 3'b010);
    chk("hex_raw_blank", {22'b0, hex_segments}, {22'b0, {42{1'b1}}});

    // Randomised traffic; the per-cycle compare checks everything here
    for (int n = 0; n < 1500; n++) begin
      bus_if.address      = (($urandom_range(0, 9) == 0) ? BASE + 32'h100 : BASE)
                            + {24'b0, offs[$urandom_range(0, 15)]} + 32'($urandom_range(0, 3));
      bus_if.write_data   = $urandom;
      bus_if.format       = fmts[$urandom_range(0, 4)];
      bus_if.read_enable  = 1'($urandom_range(0, 1));
      bus_if.write_enable = 1'($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) keys_n[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) switches = 8'($urandom);
      step();
    end
    bus_if.read_enable = 1'b0; bus_if.write_enable = 1'b0;

    // Reset in the middle of activity and a half-counted press
    keys_n = 4'hF;
    wr(32'h00, 32'hFF, 3'b010);
    rd(32'h00, 3'b010);
    chk("pre_reset_led", {32'b0, bus_if.data_fetched}, 64'hFF);
    keys_n = 4'b1011;
    idle(6);
    reset = 1'b0;
    idle(2);
    chk("rst_leds", {54'b0, leds}, 64'h0);
    chk("rst_hex", {22'b0, hex_segments}, {22'b0, {42{1'b1}}});
    chk("rst_irq", {63'b0, irq}, 64'h0);
    chk("rst_data", {32'b0, bus_if.data_fetched}, 64'h0);
    chk("rst_hit", {63'b0, bus_if.hit}, 64'h0);
    reset = 1'b1;
    idle(3);
    rd(32'h08, 3'b010);
    chk("reaccept_early", {32'b0, bus_if.data_fetched}, 64'h0);
    idle(8);
    rd(32'h08, 3'b010);
    chk("reaccept_key", {32'b0, bus_if.data_fetched}, 64'h4);
    rd(32'h0C, 3'b010);
    chk("reaccept_edge", {32'b0, bus_if.data_fetched}, 64'h4);
    rd(32'h30, 3'b010);
    chk("hole_data", {32'b0, bus_if.data_fetched}, 64'h0);
    chk("hole_hit", {63'b0, bus_if.hit}, 64'h1);
    rd(32'h100, 3'b010);
    chk("miss_hit", {63'b0, bus_if.hit}, 64'h0);
    chk("miss_data", {32'b0, bus_if.data_fetched}, 64'h0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
